// File: rtl/stopwatch_core_pkg.sv
// Shared types and constants for the stopwatch timekeeping stage.
package stopwatch_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;
  localparam int MSEC_PER_CSEC_DEFAULT = 10;

  // Value a BCD digit takes after this cycle, given its increment request.
  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic inc,
                                          input logic [3:0] max);
    if (!inc) return d;
    if (d == max) return 4'd0;
    return d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control strobes in, display digits and status out, for the stopwatch stage.
interface stopwatch_core_if;
  import stopwatch_core_pkg::*;

  // All inputs are single-cycle qualified strobes with no backpressure:
  // a strobe is consumed in the cycle it is high, there is no ready path.
  logic       clk_msec;
  logic       btn_start;
  logic       btn_lap;
  logic       btn_clear;
  logic [3:0] min10;
  logic [3:0] min1;
  logic [3:0] sec10;
  logic [3:0] sec1;
  logic [3:0] csec10;
  logic [3:0] csec1;
  logic       running;
  logic       lap_active;
  logic       wrap;
  sw_state_t  state;

  modport master (
    output clk_msec, btn_start, btn_lap, btn_clear,
    input  min10, min1, sec10, sec1, csec10, csec1,
    input  running, lap_active, wrap, state
  );

  modport slave (
    input  clk_msec, btn_start, btn_lap, btn_clear,
    output min10, min1, sec10, sec1, csec10, csec1,
    output running, lap_active, wrap, state
  );
endinterface

// File: rtl/stopwatch_core_bcd_mod_counter.sv
// One BCD digit counting 0..MAX, with a combinational carry into the next digit.
module bcd_mod_counter
  import stopwatch_core_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX9
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == MAX);

  always_ff @(posedge clk) begin
    if (reset_p || clr) digit <= 4'd0;
    else                digit <= bcd_next(digit, inc, MAX);
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: run/pause/clear FSM, msec prescaler, six-digit BCD chain and lap hold.
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int MSEC_PER_CSEC = MSEC_PER_CSEC_DEFAULT
) (
  input logic             clk,
  input logic             reset_p,
  stopwatch_core_if.slave sw
);

  localparam logic [3:0] PRESC_TC = 4'(MSEC_PER_CSEC - 1);

  sw_state_t   state;
  logic [3:0]  presc;
  logic        lap_active;
  logic        wrap_q;
  logic [23:0] lap_q;
  logic [23:0] live_next;

  logic [3:0] d_cs1, d_cs10, d_s1, d_s10, d_m1, d_m10;
  logic       c_cs1, c_cs10, c_s1, c_s10, c_m1, c_m10;
  logic       clear_ev, start_ev, lap_ev, count_en, csec_inc;

  // Priority clear > start > lap; a clear seen outside RUN is consumed even
  // in IDLE, so a coincident start does not act there.
  assign clear_ev = (state == ST_PAUSE) && sw.btn_clear;
  assign start_ev = sw.btn_start && !(sw.btn_clear && state != ST_RUN);
  assign lap_ev   = (state == ST_RUN) && sw.btn_lap && !sw.btn_start;
  assign count_en = (state == ST_RUN) && sw.clk_msec;
  assign csec_inc = count_en && (presc == PRESC_TC);

  bcd_mod_counter #(.MAX(BCD_MAX9)) u_csec1 (
    .clk(clk), .reset_p(reset_p), .clr(clear_ev), .inc(csec_inc), .digit(d_cs1), .carry(c_cs1));
  bcd_mod_counter #(.MAX(BCD_MAX9)) u_csec10 (
    .clk(clk), .reset_p(reset_p), .clr(clear_ev), .inc(c_cs1), .digit(d_cs10), .carry(c_cs10));
  bcd_mod_counter #(.MAX(BCD_MAX9)) u_sec1 (
    .clk(clk), .reset_p(reset_p), .clr(clear_ev), .inc(c_cs10), .digit(d_s1), .carry(c_s1));
  bcd_mod_counter #(.MAX(BCD_MAX5)) u_sec10 (
    .clk(clk), .reset_p(reset_p), .clr(clear_ev), .inc(c_s1), .digit(d_s10), .carry(c_s10));
  bcd_mod_counter #(.MAX(BCD_MAX9)) u_min1 (
    .clk(clk), .reset_p(reset_p), .clr(clear_ev), .inc(c_s10), .digit(d_m1), .carry(c_m1));
  bcd_mod_counter #(.MAX(BCD_MAX5)) u_min10 (
    .clk(clk), .reset_p(reset_p), .clr(clear_ev), .inc(c_m1), .digit(d_m10), .carry(c_m10));

  // Lap captures the post-edge count so a coincident increment is included.
  assign live_next = {bcd_next(d_m10, c_m1, BCD_MAX5),  bcd_next(d_m1, c_s10, BCD_MAX9),
                      bcd_next(d_s10, c_s1, BCD_MAX5),  bcd_next(d_s1, c_cs10, BCD_MAX9),
                      bcd_next(d_cs10, c_cs1, BCD_MAX9), bcd_next(d_cs1, csec_inc, BCD_MAX9)};

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state      <= ST_IDLE;
      presc      <= 4'd0;
      lap_active <= 1'b0;
      lap_q      <= 24'd0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= c_m10;
      if (clear_ev)      presc <= 4'd0;
      else if (count_en) presc <= (presc == PRESC_TC) ? 4'd0 : presc + 4'd1;
      case (state)
        ST_IDLE: if (start_ev) state <= ST_RUN;
        ST_RUN: begin
          if (start_ev) begin
            state      <= ST_PAUSE;
            lap_active <= 1'b0;
          end else if (lap_ev) begin
            lap_active <= !lap_active;
            if (!lap_active) lap_q <= live_next;
          end
        end
        ST_PAUSE: begin
          if (clear_ev) begin
            state      <= ST_IDLE;
            lap_active <= 1'b0;
            lap_q      <= 24'd0;
          end else if (start_ev) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sw.min10      = lap_active ? lap_q[23:20] : d_m10;
  assign sw.min1       = lap_active ? lap_q[19:16] : d_m1;
  assign sw.sec10      = lap_active ? lap_q[15:12] : d_s10;
  assign sw.sec1       = lap_active ? lap_q[11:8]  : d_s1;
  assign sw.csec10     = lap_active ? lap_q[7:4]   : d_cs10;
  assign sw.csec1      = lap_active ? lap_q[3:0]   : d_cs1;
  assign sw.running    = (state == ST_RUN);
  assign sw.lap_active = lap_active;
  assign sw.wrap       = wrap_q;
  assign sw.state      = state;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: run/pause, lap hold, clear priority, wrap, reset.
module tb_stopwatch_core;
  import stopwatch_core_pkg::*;

  logic clk = 1'b0;
  logic reset_p;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wrap_cnt = 0;
  logic [23:0] preload_v;

  stopwatch_core_if sw ();

  stopwatch_core #(.MSEC_PER_CSEC(10)) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .sw     (sw)
  );

  // Clock / reset block
  always #4 clk = ~clk;

  always @(negedge clk) if (sw.wrap === 1'b1) wrap_cnt++;

  function automatic logic [23:0] disp();
    return {sw.min10, sw.min1, sw.sec10, sw.sec1, sw.csec10, sw.csec1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change just after negedge, outputs read at a negedge.
  task automatic pulse(input logic s, input logic l, input logic c, input logic m);
    @(negedge clk);
    sw.btn_start = s; sw.btn_lap = l; sw.btn_clear = c; sw.clk_msec = m;
    @(negedge clk);
    sw.btn_start = 1'b0; sw.btn_lap = 1'b0; sw.btn_clear = 1'b0; sw.clk_msec = 1'b0;
  endtask

  task automatic strobe();
    @(negedge clk) sw.clk_msec = 1'b1;
    @(negedge clk) sw.clk_msec = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) strobe();
  endtask

  // Places the digit registers at preload_v; only used while paused.
  task preload();
    force dut.u_min10.digit  = preload_v[23:20];
    force dut.u_min1.digit   = preload_v[19:16];
    force dut.u_sec10.digit  = preload_v[15:12];
    force dut.u_sec1.digit   = preload_v[11:8];
    force dut.u_csec10.digit = preload_v[7:4];
    force dut.u_csec1.digit  = preload_v[3:0];
    repeat (2) @(negedge clk);
    release dut.u_min10.digit;
    release dut.u_min1.digit;
    release dut.u_sec10.digit;
    release dut.u_sec1.digit;
    release dut.u_csec10.digit;
    release dut.u_csec1.digit;
    @(negedge clk);
  endtask

  initial begin
    sw.clk_msec = 1'b0; sw.btn_start = 1'b0; sw.btn_lap = 1'b0; sw.btn_clear = 1'b0;
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    check("rst_disp", 32'(disp()), 32'h000000);
    check("rst_running", 32'(sw.running), 32'd0);
    check("rst_lap", 32'(sw.lap_active), 32'd0);
    check("rst_wrap", 32'(sw.wrap), 32'd0);
    check("rst_state", 32'(sw.state), 32'(ST_IDLE));

    // 1000 msec -> one second
    pulse(1, 0, 0, 0);
    check("t1_state", 32'(sw.state), 32'(ST_RUN));
    strobes(1000);
    check("t1_disp", 32'(disp()), 32'h000100);
    check("t1_running", 32'(sw.running), 32'd1);
    check("t1_nowrap", 32'(wrap_cnt), 32'd0);

    // Prescaler retained across pause
    pulse(1, 0, 0, 0);
    check("t2_pause", 32'(sw.state), 32'(ST_PAUSE));
    pulse(0, 0, 1, 0);
    check("t2_idle", 32'(sw.state), 32'(ST_IDLE));
    check("t2_cleared", 32'(disp()), 32'h000000);
    pulse(1, 0, 0, 0);
    strobes(25);
    check("t2_run25", 32'(disp()), 32'h000002);
    pulse(1, 0, 0, 0);
    check("t2_paused", 32'(sw.running), 32'd0);
    strobes(40);
    check("t2_hold", 32'(disp()), 32'h000002);
    pulse(1, 0, 0, 0);
    strobes(5);
    check("t2_resume", 32'(disp()), 32'h000003);

    // Lap hold
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    strobes(12340);
    check("t3_live", 32'(disp()), 32'h001234);
    pulse(0, 1, 0, 0);
    check("t3_lap_on", 32'(sw.lap_active), 32'd1);
    check("t3_lap_disp", 32'(disp()), 32'h001234);
    strobes(500);
    check("t3_frozen", 32'(disp()), 32'h001234);
    pulse(0, 1, 0, 0);
    check("t3_lap_off", 32'(sw.lap_active), 32'd0);
    check("t3_live2", 32'(disp()), 32'h001284);
    strobes(9);
    pulse(0, 1, 0, 1);
    check("t3_lap_inc", 32'(disp()), 32'h001285);
    check("t3_lap_on2", 32'(sw.lap_active), 32'd1);

    // Clear+start in RUN acts as start; clear alone in PAUSE zeroes
    pulse(1, 0, 1, 0);
    check("t5_cs_state", 32'(sw.state), 32'(ST_PAUSE));
    check("t5_cs_lap", 32'(sw.lap_active), 32'd0);
    check("t5_cs_disp", 32'(disp()), 32'h001285);
    pulse(0, 1, 0, 0);
    check("t5_lap_ign", 32'(sw.lap_active), 32'd0);
    pulse(0, 0, 1, 0);
    check("t5_clr_state", 32'(sw.state), 32'(ST_IDLE));
    check("t5_clr_disp", 32'(disp()), 32'h000000);

    // Wrap 59:59.99 -> 00:00.00
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    preload_v = 24'h595999;
    preload();
    check("t4_preload", 32'(disp()), 32'h595999);
    pulse(1, 0, 0, 0);
    strobes(9);
    check("t4_pre_wrap", 32'(disp()), 32'h595999);
    check("t4_wrap_low", 32'(sw.wrap), 32'd0);
    @(negedge clk) sw.clk_msec = 1'b1;
    @(negedge clk) sw.clk_msec = 1'b0;
    check("t4_zero", 32'(disp()), 32'h000000);
    check("t4_wrap_hi", 32'(sw.wrap), 32'd1);
    check("t4_running", 32'(sw.running), 32'd1);
    @(negedge clk);
    check("t4_wrap_drop", 32'(sw.wrap), 32'd0);
    check("t4_wrap_cnt", 32'(wrap_cnt), 32'd1);

    // Strobe with start leaving RUN counts; entering RUN does not
    strobes(9);
    pulse(1, 0, 0, 1);
    check("t6_leave", 32'(disp()), 32'h000001);
    check("t6_state", 32'(sw.state), 32'(ST_PAUSE));
    pulse(1, 0, 0, 1);
    strobes(9);
    check("t6_enter", 32'(disp()), 32'h000001);
    strobe();
    check("t6_enter2", 32'(disp()), 32'h000002);

    // Reset mid-run with a coincident carrying strobe
    pulse(1, 0, 0, 0);
    preload_v = 24'h004567;
    preload();
    pulse(1, 0, 0, 0);
    strobes(9);
    check("t7_at", 32'(disp()), 32'h004567);
    @(negedge clk) begin reset_p = 1'b1; sw.clk_msec = 1'b1; end
    @(negedge clk) begin reset_p = 1'b0; sw.clk_msec = 1'b0; end
    check("t7_disp", 32'(disp()), 32'h000000);
    check("t7_running", 32'(sw.running), 32'd0);
    check("t7_state", 32'(sw.state), 32'(ST_IDLE));
    check("t7_wrap", 32'(sw.wrap), 32'd0);
    pulse(1, 0, 0, 0);
    strobes(9);
    check("t7_presc0", 32'(disp()), 32'h000000);
    strobe();
    check("t7_count", 32'(disp()), 32'h000001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
